ocp_master_arbiter: RTL and testbench
=====================================

# ocp_master_arbiter

Round-robin arbiter that shares one OCP 3.0 master port between `NREQ` bridge-side requesters, such as PCIe read/write channels.
- Latches the winning request and drives `MCmd`/`MAddr`/`MData` until the slave asserts `SCmdAccept`.
- Tracks outstanding reads in order, so each in-order `SResp` is routed back to the requester that issued it.
- Sits between the bridge request logic and the OCP bus, in place of a directly driven master FSM.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 64: OCP address width.
- `DATA_W`, 8: OCP data width.
- `OUTST_DEPTH`, 4: outstanding-response FIFO depth; must be a power of two.

Ports:
- `Clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `EnableClk`  in  1  when low, all state is held
- `req_valid`  in  NREQ  request pending, per requester
- `req_write`  in  NREQ  1 = write, 0 = read
- `req_addr`  in  NREQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- `req_wdata`  in  NREQ*DATA_W  packed write data, same packing rule
- `req_ready`  out  NREQ  one-cycle pulse: request accepted by the slave
- `resp_valid`  out  NREQ  one-cycle pulse: response for requester i
- `resp_data`  out  DATA_W  `SData` captured with the response
- `resp_err`  out  1  response was FAIL or ERR
- `stray_resp`  out  1  sticky: a response arrived with no outstanding entry
- `MCmd`  out  3  OCP command: IDLE=000, WR=001, RD=010, WRNP=101
- `MAddr`  out  ADDR_W  OCP address
- `MData`  out  DATA_W  OCP write data
- `MRespAccept`  out  1  tied to 1
- `SCmdAccept`  in  1  slave accepts the current command
- `SResp`  in  2  slave response: NULL=00, DVA=01, FAIL=10, ERR=11
- `SData`  in  DATA_W  slave read data

## Operation
State machine has two states:
- **ARB**:
  - Eligible requesters have `req_valid`=1, with reads additionally requiring the FIFO count < `OUTST_DEPTH`.
  - The winner is the first eligible index at or after `rr_ptr`, scanning upward with wrap-around.
  - On a win: latch the winner's index, command, address and data, then go to ISSUE.
  - With no eligible requester: stay in ARB.
- **ISSUE**:
  - Drive the latched command.
  - While `SCmdAccept`=1: `req_ready[grant]`=1 (combinational). On the next edge: push `grant` into the FIFO if the command was a read, set `rr_ptr`=(grant+1) mod NREQ, go to ARB.
  - While `SCmdAccept`=0: hold all outputs stable.

Response handling:
- Any `SResp`≠NULL with the FIFO non-empty pops the head index h. Next cycle: `resp_valid[h]`=1, `resp_data`=`SData`, `resp_err`=(`SResp`[1]).
- `SResp`≠NULL with the FIFO empty: no pop; set `stray_resp`.

Write handling (base build): writes are posted, issued as `MCmd`=WR. They produce no response, occupy no FIFO entry and are never blocked by FIFO full.

Requester obligation: keep `req_valid` and payload stable until `req_ready`. The arbiter samples the payload only at the win edge.

Reset values:
- `MCmd`=IDLE, `MAddr`=0, `MData`=0
- `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_err`=0, `stray_resp`=0
- state=ARB, `rr_ptr`=0, FIFO empty

## Timing
- Win at edge k; `MCmd`/`MAddr`/`MData` valid from cycle k+1.
- `SCmdAccept` sampled high at edge m; `MCmd`=IDLE from cycle m+1. There is always at least one IDLE cycle between commands.
- Response latency is one cycle, registered: `SResp` at edge r gives `resp_valid` during cycle r+1.
- Push and pop in the same cycle are both performed and the count is unchanged.
- FIFO full is evaluated on the count before the current cycle's pop, so a pop does not free a slot until the following cycle.
- `reset` asserted mid-transaction:
  - The command is dropped and the FIFO is cleared.
  - No `req_ready` pulse is issued for the dropped command.
  - Responses arriving after reset for pre-reset reads count as stray.
- `reset` has priority over `EnableClk`=0.

## Configuration
- `OCP_ARB_WRITE_RESP_EN` defined:
  - Writes are issued as WRNP.
  - Each write pushes its index into the FIFO and is subject to the FIFO-full check.
  - The write's response pulses `resp_valid` with `resp_data`=`SData`.
- `OCP_ARB_WRITE_RESP_EN` undefined: posted WR behaviour as described in Operation.

## Structure
- Shared package `ocp_pkg` holds the MCmd and SResp encodings; the OCP master FSM uses the same package.
- Sub-module `ocp_resp_fifo` (width $clog2(NREQ), depth `OUTST_DEPTH`):
  - Ports: push, pop, head, count, full, empty.
  - Reused by other bus masters.

## Test plan
- **Single read:** requester 2 reads addr 0x10; `SCmdAccept` held 0 for 3 cycles, then 1; `SResp`=DVA, `SData`=0xA5 two cycles later. Expect: `MCmd`=RD held 4 cycles; `req_ready[2]` pulses once; `resp_valid[2]`=1 with `resp_data`=0xA5 and `resp_err`=0.
- **Round-robin fairness:** all 4 requesters continuously valid, `SCmdAccept`=1. Expect grant order 0,1,2,3,0; one command every 2 cycles.
- **FIFO full:** 4 reads accepted with no responses, then a 5th read and one write. Expect: the write issues, the read waits. After a DVA, the read issues from the cycle after the pop.
- **Out-of-range responses:** `SResp`=ERR with one read outstanding → `resp_err`=1. `SResp`=DVA with the FIFO empty → `stray_resp`=1 and no `resp_valid`.
- **Reset mid-operation:** `reset` during ISSUE with 2 reads outstanding. Expect: `MCmd`=IDLE next cycle, no `req_ready`, FIFO empty, `rr_ptr`=0.
- **With `OCP_ARB_WRITE_RESP_EN`:** a write to 0x20 with data 0x3C. Expect `MCmd`=WRNP; DVA then gives `resp_valid` to the issuing requester.

Source files
------------

// File: rtl/ocp_pkg.sv
// Shared OCP 3.0 encodings used by the OCP masters and the request arbiter.
package ocp_pkg;

  // OCP master command encoding
  typedef enum logic [2:0] {
    MCMD_IDLE = 3'b000,
    MCMD_WR   = 3'b001,
    MCMD_RD   = 3'b010,
    MCMD_WRNP = 3'b101
  } mcmd_e;

  // OCP slave response encoding
  typedef enum logic [1:0] {
    SRESP_NULL = 2'b00,
    SRESP_DVA  = 2'b01,
    SRESP_FAIL = 2'b10,
    SRESP_ERR  = 2'b11
  } sresp_e;

  // Arbiter control states
  typedef enum logic {
    ARB_ST_ARB   = 1'b0,
    ARB_ST_ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ocp_resp_fifo.sv
// Small in-order FIFO of requester indices for outstanding OCP responses.
// Push and pop in the same cycle are both performed; a push into a full FIFO
// is only accepted when a pop frees the head in that same cycle.
module ocp_resp_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  // Storage write; contents need no reset since count guards every read
  always_ff @(posedge Clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/ocp_master_arbiter.sv
// Round-robin arbiter sharing one OCP master port between NREQ requesters.
// Reads are tracked in order so each response returns to its issuer.
// Build option OCP_ARB_WRITE_RESP_EN: writes issue as WRNP and are tracked
// like reads; otherwise writes are posted WR commands.
module ocp_master_arbiter
  import ocp_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned OUTST_DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     EnableClk,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     resp_err,
  output logic                     stray_resp,
  output logic [2:0]               MCmd,
  output logic [ADDR_W-1:0]        MAddr,
  output logic [DATA_W-1:0]        MData,
  output logic                     MRespAccept,
  input  logic                     SCmdAccept,
  input  logic [1:0]               SResp,
  input  logic [DATA_W-1:0]        SData
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(OUTST_DEPTH) + 1;

`ifdef OCP_ARB_WRITE_RESP_EN
  localparam logic  WR_RESP = 1'b1;
  localparam mcmd_e WR_CMD  = MCMD_WRNP;
`else
  localparam logic  WR_RESP = 1'b0;
  localparam mcmd_e WR_CMD  = MCMD_WR;
`endif

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_grant;
  logic [IDX_W-1:0]  w_win_idx;
  logic              w_win_found;
  logic [NREQ-1:0]   w_elig;
  logic              w_room;
  mcmd_e             r_mcmd;
  logic [ADDR_W-1:0] r_maddr;
  logic [DATA_W-1:0] r_mdata;
  logic              r_track;
  logic              w_load;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_resp_any;
  logic [IDX_W-1:0]  w_fifo_head;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [ADDR_W-1:0] w_addr_arr [NREQ];
  logic [DATA_W-1:0] w_data_arr [NREQ];

  // Unpack per-requester payloads
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign w_data_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  // Eligibility: tracked commands need a free slot (count before this cycle's pop)
  always_comb begin
    w_room = (w_fifo_count < CNT_W'(OUTST_DEPTH));
    w_elig = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      w_elig[i] = req_valid[i] && (w_room || (req_write[i] && !WR_RESP));
    end
  end

  // Round-robin scan upward from rr_ptr with wrap-around
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int off = 0; off < int'(NREQ); off++) begin
      if (!w_win_found && w_elig[IDX_W'((int'(r_rr_ptr) + off) % int'(NREQ))]) begin
        w_win_found = 1'b1;
        w_win_idx   = IDX_W'((int'(r_rr_ptr) + off) % int'(NREQ));
      end
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state <= ARB_ST_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, latch/accept strobes and the combinational ready pulse
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    req_ready   = '0;
    if (EnableClk && !reset) begin
      case (r_state)
        ARB_ST_ARB: begin
          if (w_win_found) begin
            w_load      = 1'b1;
            w_state_nxt = ARB_ST_ISSUE;
          end
        end
        ARB_ST_ISSUE: begin
          if (SCmdAccept) begin
            w_accept    = 1'b1;
            req_ready   = NREQ'(1) << r_grant;
            w_state_nxt = ARB_ST_ARB;
          end
        end
        default: w_state_nxt = ARB_ST_ARB;
      endcase
    end
  end

  // Latch the winning command and advance the round-robin pointer on accept
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_mcmd   <= MCMD_IDLE;
      r_maddr  <= '0;
      r_mdata  <= '0;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_track  <= 1'b0;
    end else if (w_load) begin
      r_grant <= w_win_idx;
      r_mcmd  <= req_write[w_win_idx] ? WR_CMD : MCMD_RD;
      r_maddr <= w_addr_arr[w_win_idx];
      r_mdata <= w_data_arr[w_win_idx];
      r_track <= !req_write[w_win_idx] || WR_RESP;
    end else if (w_accept) begin
      r_mcmd   <= MCMD_IDLE;
      r_rr_ptr <= (r_grant == IDX_W'(NREQ - 1)) ? '0 : r_grant + IDX_W'(1);
    end
  end

  assign w_resp_any = EnableClk && !reset && (SResp != SRESP_NULL);
  assign w_pop      = w_resp_any && !w_fifo_empty;
  assign w_push     = w_accept && r_track && (!w_fifo_full || w_pop);

  ocp_resp_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (OUTST_DEPTH)
  ) u_resp_fifo (
    .Clk       (Clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (r_grant),
    .pop       (w_pop),
    .head      (w_fifo_head),
    .count     (w_fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // Route each response to the head requester; flag responses with nothing outstanding
  always_ff @(posedge Clk) begin
    if (reset) begin
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      stray_resp <= 1'b0;
    end else if (EnableClk) begin
      resp_valid <= '0;
      if (w_pop) begin
        resp_valid <= NREQ'(1) << w_fifo_head;
        resp_data  <= SData;
        resp_err   <= SResp[1];
      end else if (w_resp_any) begin
        stray_resp <= 1'b1;
      end
    end
  end

  assign MCmd        = r_mcmd;
  assign MAddr       = r_maddr;
  assign MData       = r_mdata;
  assign MRespAccept = 1'b1;

endmodule

// File: tb/tb_ocp_master_arbiter.sv
// Directed bench for ocp_master_arbiter: vector table plus multi-cycle sequences.
module tb_ocp_master_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;

  localparam logic [2:0] C_IDLE = 3'b000;
  localparam logic [2:0] C_WR   = 3'b001;
  localparam logic [2:0] C_RD   = 3'b010;
  localparam logic [2:0] C_WRNP = 3'b101;
  localparam logic [1:0] R_NULL = 2'b00;
  localparam logic [1:0] R_DVA  = 2'b01;
  localparam logic [1:0] R_ERR  = 2'b11;

  logic                   Clk = 1'b0;
  logic                   reset;
  logic                   EnableClk;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        resp_valid;
  logic [DATA_W-1:0]      resp_data;
  logic                   resp_err;
  logic                   stray_resp;
  logic [2:0]             MCmd;
  logic [ADDR_W-1:0]      MAddr;
  logic [DATA_W-1:0]      MData;
  logic                   MRespAccept;
  logic                   SCmdAccept;
  logic [1:0]             SResp;
  logic [DATA_W-1:0]      SData;

  logic [ADDR_W-1:0] addr_tab [NREQ];
  logic [DATA_W-1:0] wd_tab   [NREQ];

  assign req_addr  = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
  assign req_wdata = {wd_tab[3], wd_tab[2], wd_tab[1], wd_tab[0]};

  int n_cmp = 0;
  int n_mis = 0;

  ocp_master_arbiter #(
    .NREQ        (NREQ),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .OUTST_DEPTH (DEPTH)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .EnableClk   (EnableClk),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .stray_resp  (stray_resp),
    .MCmd        (MCmd),
    .MAddr       (MAddr),
    .MData       (MData),
    .MRespAccept (MRespAccept),
    .SCmdAccept  (SCmdAccept),
    .SResp       (SResp),
    .SData       (SData)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  task automatic set_in(input logic [3:0] v, input logic [3:0] w, input logic acc,
                        input logic [1:0] sr, input logic [7:0] sd);
    req_valid  = v;
    req_write  = w;
    SCmdAccept = acc;
    SResp      = sr;
    SData      = sd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(4'h0, 4'h0, 1'b0, R_NULL, 8'h00);
    tick();
    reset = 1'b0;
  endtask

`ifndef OCP_ARB_WRITE_RESP_EN
  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  w;
    logic        acc;
    logic [1:0]  sr;
    logic [7:0]  sd;
    logic [2:0]  e_cmd;
    logic [63:0] e_addr;
    logic [7:0]  e_data;
    logic [3:0]  e_rdy;
    logic [3:0]  e_rv;
    logic [7:0]  e_rd;
    logic        e_err;
    logic        e_stray;
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl [NVEC];
`endif

  initial begin
    addr_tab[0] = 64'h1000; addr_tab[1] = 64'h2000;
    addr_tab[2] = 64'h0010; addr_tab[3] = 64'h4000;
    wd_tab[0] = 8'hD0; wd_tab[1] = 8'hD1; wd_tab[2] = 8'hD2; wd_tab[3] = 8'hD3;
    EnableClk = 1'b1;
    reset     = 1'b1;
    set_in(4'h0, 4'h0, 1'b0, R_NULL, 8'h00);
    tick();
    tick();

`ifndef OCP_ARB_WRITE_RESP_EN
    // rst v w acc sresp sdata | cmd addr data ready rv rdata err stray
    tbl[0]  = '{1, 4'h0, 4'h0, 0, R_NULL, 8'h00, C_IDLE, 64'h0,    8'h00, 4'h0, 4'h0, 8'h00, 0, 0};
    // single read from requester 2, accept delayed 3 cycles
    tbl[1]  = '{0, 4'h4, 4'h0, 0, R_NULL, 8'h00, C_IDLE, 64'h0,    8'h00, 4'h0, 4'h0, 8'h00, 0, 0};
    tbl[2]  = '{0, 4'h4, 4'h0, 0, R_NULL, 8'h00, C_RD,   64'h10,   8'hD2, 4'h0, 4'h0, 8'h00, 0, 0};
    tbl[3]  = '{0, 4'h4, 4'h0, 0, R_NULL, 8'h00, C_RD,   64'h10,   8'hD2, 4'h0, 4'h0, 8'h00, 0, 0};
    tbl[4]  = '{0, 4'h4, 4'h0, 0, R_NULL, 8'h00, C_RD,   64'h10,   8'hD2, 4'h0, 4'h0, 8'h00, 0, 0};
    tbl[5]  = '{0, 4'h4, 4'h0, 1, R_NULL, 8'h00, C_RD,   64'h10,   8'hD2, 4'h4, 4'h0, 8'h00, 0, 0};
    tbl[6]  = '{0, 4'h0, 4'h0, 0, R_NULL, 8'h00, C_IDLE, 64'h10,   8'hD2, 4'h0, 4'h0, 8'h00, 0, 0};
    tbl[7]  = '{0, 4'h0, 4'h0, 0, R_DVA,  8'hA5, C_IDLE, 64'h10,   8'hD2, 4'h0, 4'h0, 8'h00, 0, 0};
    tbl[8]  = '{0, 4'h0, 4'h0, 0, R_NULL, 8'h00, C_IDLE, 64'h10,   8'hD2, 4'h0, 4'h4, 8'hA5, 0, 0};
    tbl[9]  = '{0, 4'h0, 4'h0, 0, R_NULL, 8'h00, C_IDLE, 64'h10,   8'hD2, 4'h0, 4'h0, 8'hA5, 0, 0};
    // reset, then round robin with all requesters writing and immediate accept
    tbl[10] = '{1, 4'h0, 4'h0, 0, R_NULL, 8'h00, C_IDLE, 64'h10,   8'hD2, 4'h0, 4'h0, 8'hA5, 0, 0};
    tbl[11] = '{0, 4'hF, 4'hF, 1, R_NULL, 8'h00, C_IDLE, 64'h0,    8'h00, 4'h0, 4'h0, 8'h00, 0, 0};
    tbl[12] = '{0, 4'hF, 4'hF, 1, R_NULL, 8'h00, C_WR,   64'h1000, 8'hD0, 4'h1, 4'h0, 8'h00, 0, 0};
    tbl[13] = '{0, 4'hF, 4'hF, 1, R_NULL, 8'h00, C_IDLE, 64'h1000, 8'hD0, 4'h0, 4'h0, 8'h00, 0, 0};
    tbl[14] = '{0, 4'hF, 4'hF, 1, R_NULL, 8'h00, C_WR,   64'h2000, 8'hD1, 4'h2, 4'h0, 8'h00, 0, 0};
    tbl[15] = '{0, 4'hF, 4'hF, 1, R_NULL, 8'h00, C_IDLE, 64'h2000, 8'hD1, 4'h0, 4'h0, 8'h00, 0, 0};
    tbl[16] = '{0, 4'hF, 4'hF, 1, R_NULL, 8'h00, C_WR,   64'h10,   8'hD2, 4'h4, 4'h0, 8'h00, 0, 0};
    tbl[17] = '{0, 4'hF, 4'hF, 1, R_NULL, 8'h00, C_IDLE, 64'h10,   8'hD2, 4'h0, 4'h0, 8'h00, 0, 0};
    tbl[18] = '{0, 4'hF, 4'hF, 1, R_NULL, 8'h00, C_WR,   64'h4000, 8'hD3, 4'h8, 4'h0, 8'h00, 0, 0};
    tbl[19] = '{0, 4'hF, 4'hF, 1, R_NULL, 8'h00, C_IDLE, 64'h4000, 8'hD3, 4'h0, 4'h0, 8'h00, 0, 0};
    tbl[20] = '{0, 4'hF, 4'hF, 1, R_NULL, 8'h00, C_WR,   64'h1000, 8'hD0, 4'h1, 4'h0, 8'h00, 0, 0};
    tbl[21] = '{0, 4'h0, 4'h0, 1, R_NULL, 8'h00, C_IDLE, 64'h1000, 8'hD0, 4'h0, 4'h0, 8'h00, 0, 0};

    for (int i = 0; i < NVEC; i++) begin
      reset = tbl[i].rst;
      set_in(tbl[i].v, tbl[i].w, tbl[i].acc, tbl[i].sr, tbl[i].sd);
      sample();
      chk($sformatf("row%0d.MCmd", i),       64'(MCmd),       64'(tbl[i].e_cmd));
      chk($sformatf("row%0d.MAddr", i),      MAddr,           tbl[i].e_addr);
      chk($sformatf("row%0d.MData", i),      64'(MData),      64'(tbl[i].e_data));
      chk($sformatf("row%0d.req_ready", i),  64'(req_ready),  64'(tbl[i].e_rdy));
      chk($sformatf("row%0d.resp_valid", i), 64'(resp_valid), 64'(tbl[i].e_rv));
      chk($sformatf("row%0d.resp_data", i),  64'(resp_data),  64'(tbl[i].e_rd));
      chk($sformatf("row%0d.resp_err", i),   64'(resp_err),   64'(tbl[i].e_err));
      chk($sformatf("row%0d.stray", i),      64'(stray_resp), 64'(tbl[i].e_stray));
      tick();
    end
    chk("MRespAccept", 64'(MRespAccept), 64'h1);

    // FIFO full: four reads outstanding, then a read blocked behind a write
    do_reset();
    set_in(4'hF, 4'h0, 1'b1, R_NULL, 8'h00);
    for (int k = 0; k < 8; k++) begin
      sample();
      chk($sformatf("full.fill%0d.ready", k), 64'(req_ready),
          (k % 2 == 1) ? 64'(4'(1) << (k / 2)) : 64'h0);
      chk($sformatf("full.fill%0d.cmd", k), 64'(MCmd), (k % 2 == 1) ? 64'(C_RD) : 64'(C_IDLE));
      tick();
    end
    set_in(4'b0011, 4'b0010, 1'b1, R_NULL, 8'h00);
    sample(); chk("full.c8.cmd", 64'(MCmd), 64'(C_IDLE)); tick();
    sample();
    chk("full.c9.cmd", 64'(MCmd), 64'(C_WR));
    chk("full.c9.addr", MAddr, 64'h2000);
    chk("full.c9.ready", 64'(req_ready), 64'h2);
    tick();
    set_in(4'b0001, 4'b0000, 1'b1, R_NULL, 8'h00);
    sample();
    chk("full.c10.cmd", 64'(MCmd), 64'(C_IDLE));
    chk("full.c10.ready", 64'(req_ready), 64'h0);
    tick();
    set_in(4'b0001, 4'b0000, 1'b1, R_DVA, 8'h5A);
    sample();
    chk("full.c11.cmd", 64'(MCmd), 64'(C_IDLE));
    chk("full.c11.rv", 64'(resp_valid), 64'h0);
    tick();
    set_in(4'b0001, 4'b0000, 1'b1, R_NULL, 8'h00);
    sample();
    chk("full.c12.cmd", 64'(MCmd), 64'(C_IDLE));
    chk("full.c12.rv", 64'(resp_valid), 64'h1);
    chk("full.c12.rdata", 64'(resp_data), 64'h5A);
    tick();
    sample();
    chk("full.c13.cmd", 64'(MCmd), 64'(C_RD));
    chk("full.c13.addr", MAddr, 64'h1000);
    chk("full.c13.ready", 64'(req_ready), 64'h1);
    tick();

    // ERR response routed with resp_err; DVA with nothing outstanding is stray
    do_reset();
    set_in(4'b1000, 4'b0000, 1'b1, R_NULL, 8'h00);
    sample(); chk("err.b0.cmd", 64'(MCmd), 64'(C_IDLE)); tick();
    sample();
    chk("err.b1.cmd", 64'(MCmd), 64'(C_RD));
    chk("err.b1.addr", MAddr, 64'h4000);
    chk("err.b1.ready", 64'(req_ready), 64'h8);
    tick();
    set_in(4'h0, 4'h0, 1'b0, R_ERR, 8'hEE);
    sample(); chk("err.b2.rv", 64'(resp_valid), 64'h0); tick();
    set_in(4'h0, 4'h0, 1'b0, R_DVA, 8'h77);
    sample();
    chk("err.b3.rv", 64'(resp_valid), 64'h8);
    chk("err.b3.rdata", 64'(resp_data), 64'hEE);
    chk("err.b3.rerr", 64'(resp_err), 64'h1);
    chk("err.b3.stray", 64'(stray_resp), 64'h0);
    tick();
    set_in(4'h0, 4'h0, 1'b0, R_NULL, 8'h00);
    sample();
    chk("stray.b4.rv", 64'(resp_valid), 64'h0);
    chk("stray.b4.stray", 64'(stray_resp), 64'h1);
    chk("stray.b4.rdata", 64'(resp_data), 64'hEE);
    tick();
    sample(); chk("stray.b5.sticky", 64'(stray_resp), 64'h1); tick();

    // EnableClk low freezes an accept in progress
    do_reset();
    set_in(4'b0001, 4'b0000, 1'b0, R_NULL, 8'h00);
    sample(); tick();
    sample(); chk("en.e1.cmd", 64'(MCmd), 64'(C_RD)); tick();
    EnableClk = 1'b0;
    SCmdAccept = 1'b1;
    sample();
    chk("en.e2.ready", 64'(req_ready), 64'h0);
    chk("en.e2.cmd", 64'(MCmd), 64'(C_RD));
    tick();
    EnableClk = 1'b1;
    sample();
    chk("en.e3.cmd", 64'(MCmd), 64'(C_RD));
    chk("en.e3.ready", 64'(req_ready), 64'h1);
    tick();
    set_in(4'h0, 4'h0, 1'b0, R_NULL, 8'h00);
    sample(); chk("en.e4.cmd", 64'(MCmd), 64'(C_IDLE)); tick();

    // Reset during ISSUE with two reads outstanding
    do_reset();
    set_in(4'b0011, 4'b0000, 1'b1, R_NULL, 8'h00);
    for (int k = 0; k < 4; k++) begin
      sample();
      chk($sformatf("rst.c%0d.ready", k), 64'(req_ready),
          (k == 1) ? 64'h1 : ((k == 3) ? 64'h2 : 64'h0));
      tick();
    end
    set_in(4'b0100, 4'b0000, 1'b0, R_NULL, 8'h00);
    sample(); chk("rst.c4.cmd", 64'(MCmd), 64'(C_IDLE)); tick();
    reset = 1'b1;
    SCmdAccept = 1'b1;
    sample();
    chk("rst.c5.cmd", 64'(MCmd), 64'(C_RD));
    chk("rst.c5.addr", MAddr, 64'h10);
    chk("rst.c5.ready", 64'(req_ready), 64'h0);
    tick();
    reset = 1'b0;
    set_in(4'h0, 4'h0, 1'b0, R_DVA, 8'h42);
    sample();
    chk("rst.c6.cmd", 64'(MCmd), 64'(C_IDLE));
    chk("rst.c6.addr", MAddr, 64'h0);
    chk("rst.c6.ready", 64'(req_ready), 64'h0);
    chk("rst.c6.stray", 64'(stray_resp), 64'h0);
    tick();
    set_in(4'b0110, 4'b0110, 1'b1, R_NULL, 8'h00);
    sample();
    chk("rst.c7.stray", 64'(stray_resp), 64'h1);
    chk("rst.c7.rv", 64'(resp_valid), 64'h0);
    chk("rst.c7.cmd", 64'(MCmd), 64'(C_IDLE));
    tick();
    sample();
    chk("rst.c8.cmd", 64'(MCmd), 64'(C_WR));
    chk("rst.c8.addr", MAddr, 64'h2000);
    chk("rst.c8.ready", 64'(req_ready), 64'h2);
    tick();
    set_in(4'h0, 4'h0, 1'b0, R_NULL, 8'h00);
`else
    // Non-posted write gets a routed response
    addr_tab[1] = 64'h20;
    wd_tab[1]   = 8'h3C;
    do_reset();
    set_in(4'b0010, 4'b0010, 1'b1, R_NULL, 8'h00);
    sample();
    chk("wrnp.w0.cmd", 64'(MCmd), 64'(C_IDLE));
    chk("wrnp.w0.ready", 64'(req_ready), 64'h0);
    tick();
    sample();
    chk("wrnp.w1.cmd", 64'(MCmd), 64'(C_WRNP));
    chk("wrnp.w1.addr", MAddr, 64'h20);
    chk("wrnp.w1.data", 64'(MData), 64'h3C);
    chk("wrnp.w1.ready", 64'(req_ready), 64'h2);
    tick();
    set_in(4'h0, 4'h0, 1'b0, R_DVA, 8'h99);
    sample();
    chk("wrnp.w2.cmd", 64'(MCmd), 64'(C_IDLE));
    chk("wrnp.w2.rv", 64'(resp_valid), 64'h0);
    tick();
    set_in(4'h0, 4'h0, 1'b0, R_NULL, 8'h00);
    sample();
    chk("wrnp.w3.rv", 64'(resp_valid), 64'h2);
    chk("wrnp.w3.rdata", 64'(resp_data), 64'h99);
    chk("wrnp.w3.rerr", 64'(resp_err), 64'h0);
    chk("wrnp.w3.stray", 64'(stray_resp), 64'h0);
    tick();
    chk("wrnp.MRespAccept", 64'(MRespAccept), 64'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
